// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions: master FSM states and response codes.
package axi_pkg;

    localparam int unsigned RESP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_RSP
    } state_e;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one cmd into an AW/W/B or AR/R
// sequence and returns the slave response on the rsp port.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [RESP_W-1:0] rsp_resp,
    output logic              rsp_write,
    output logic              awvalid,
    output logic [ADDR_W-1:0] awaddr,
    input  logic              awready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    input  logic              wready,
    input  logic              bvalid,
    input  logic [RESP_W-1:0] bresp,
    output logic              bready,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [RESP_W-1:0] rresp,
    output logic              rready
);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [RESP_W-1:0]   rsp_resp_q, rsp_resp_d;

    // Next state; address/data registers double as the command holding registers.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d = cmd_addr;
                        wdata_d  = cmd_wdata;
                        state_d  = ST_AW;
                    end else begin
                        araddr_d = cmd_addr;
                        state_d  = ST_AR;
                    end
                end
            end
            ST_AW:  if (awvalid_q && awready) state_d = ST_W;
            ST_W:   if (wvalid_q && wready)   state_d = ST_B;
            ST_B: begin
                if (bvalid && bready_q) begin
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                    state_d     = ST_RSP;
                end
            end
            ST_AR:  if (arvalid_q && arready) state_d = ST_R;
            ST_R: begin
                if (rvalid && rready_q) begin
                    rsp_resp_d  = rresp;
                    rsp_rdata_d = rdata;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are decoded from the next state so they leave flops.
        cmd_ready_d = (state_d == ST_IDLE);
        awvalid_d   = (state_d == ST_AW);
        wvalid_d    = (state_d == ST_W);
        bready_d    = (state_d == ST_B);
        arvalid_d   = (state_d == ST_AR);
        rready_d    = (state_d == ST_R);
        rsp_valid_d = (state_d == ST_RSP);
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;

endmodule
